// File: rtl/raster_pkg.sv
// Shared rasterizer types: frame-buffer geometry, the pixel record and the writer FSM states.
package raster_pkg;

    localparam int FB_WIDTH  = 640;
    localparam int FB_HEIGHT = 480;
    localparam int FB_ADDR_W = 26;
    localparam int COLOR_W   = 24;

    typedef struct packed {
        logic [25:0] addr;
        logic [23:0] color;
    } pixel_t;

    typedef enum logic [1:0] {
        PW_IDLE,
        PW_RUN,
        PW_FLUSH,
        PW_DONE
    } pw_state_t;

endpackage

// File: rtl/pixel_fifo.sv
// Synchronous pixel FIFO; full/empty come from the registered count only.
module pixel_fifo
    import raster_pkg::*;
#(
    parameter int  DEPTH = 8,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = PTR_W + 1
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             push,
    input  pixel_t           din,
    input  logic             pop,
    output pixel_t           dout,
    output logic [CNT_W-1:0] count,
    output logic             full,
    output logic             empty
);

    pixel_t           mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             push_ok;
    logic             pop_ok;

    assign full    = (count_q == CNT_W'(DEPTH));
    assign empty   = (count_q == '0);
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;
    assign count   = count_q;
    assign dout    = mem_q[rd_ptr_q];

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_ok) wr_ptr_d = wr_ptr_q + 1'b1;
        if (pop_ok)  rd_ptr_d = rd_ptr_q + 1'b1;
        case ({push_ok, pop_ok})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: nothing is read before the count says it was written.
    always_ff @(posedge clock) begin
        if (push_ok) mem_q[wr_ptr_q] <= din;
    end

endmodule

// File: rtl/fb_pixel_writer.sv
// Rasterizer pixel sink: buffers pixels, writes them to the frame buffer over an Avalon write
// master, back-pressures the source, and forwards end-of-triangle once all its pixels are written.
module fb_pixel_writer
    import raster_pkg::*;
#(
    parameter int ADDR_W       = FB_ADDR_W,
    parameter int COLOR_W      = raster_pkg::COLOR_W,
    parameter int FIFO_DEPTH   = 8,
    parameter int STALL_MARGIN = 2
) (
    input  logic               clock,
    input  logic               reset,
    input  logic [ADDR_W-1:0]  pix_addr,
    input  logic [COLOR_W-1:0] pix_color,
    input  logic               pix_valid,
    input  logic               done_in,
    output logic               stall_out,
    output logic [ADDR_W-1:0]  mem_address,
    output logic [31:0]        mem_writedata,
    output logic [3:0]         mem_byteenable,
    output logic               mem_write,
    input  logic               mem_waitrequest,
    output logic               done_out,
    output logic               overflow,
    output pw_state_t          dbg_state
);

    localparam int               CNT_W    = $clog2(FIFO_DEPTH) + 1;
    localparam logic [CNT_W-1:0] STALL_AT = CNT_W'(FIFO_DEPTH - STALL_MARGIN);

    pw_state_t         state_q, state_d;
    logic              done_pend_q, done_pend_d;
    logic              stall_q, stall_d;
    logic              overflow_q, overflow_d;
    logic              mem_write_q, mem_write_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [31:0]       wdata_q, wdata_d;

    pixel_t            fifo_din;
    pixel_t            fifo_dout;
    logic [CNT_W-1:0]  fifo_count;
    logic [CNT_W-1:0]  count_next;
    logic              fifo_full;
    logic              fifo_empty;
    logic              push_ok;
    logic              load;
    logic              drained;

    assign fifo_din = '{addr: pix_addr, color: pix_color};

    pixel_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clock (clock),
        .reset (reset),
        .push  (pix_valid),
        .din   (fifo_din),
        .pop   (load),
        .dout  (fifo_dout),
        .count (fifo_count),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    // Bus handshake: a word is offered while mem_write=1 and transfers on the rising edge where
    // mem_waitrequest=0; until then address and data hold. The output register refills from the
    // FIFO in that same transfer cycle, so back-to-back words go out one per clock.
    assign push_ok    = pix_valid && !fifo_full;
    assign load       = (!mem_write_q || !mem_waitrequest) && !fifo_empty;
    assign count_next = fifo_count + CNT_W'(push_ok) - CNT_W'(load);
    // A pixel arriving this cycle still belongs to the triangle being flushed.
    assign drained    = fifo_empty && !mem_write_q && !pix_valid;

    always_comb begin
        mem_write_d = mem_write_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        stall_d     = (count_next >= STALL_AT);
        overflow_d  = overflow_q || (pix_valid && fifo_full);
        if (load) begin
            mem_write_d = 1'b1;
            addr_d      = fifo_dout.addr;
            wdata_d     = {8'h00, fifo_dout.color};
        end else if (mem_write_q && !mem_waitrequest) begin
            mem_write_d = 1'b0;
        end
    end

    always_comb begin
        state_d     = state_q;
        done_pend_d = done_pend_q;
        case (state_q)
            PW_IDLE: begin
                if (done_in || done_pend_q) begin
                    state_d     = PW_FLUSH;
                    done_pend_d = done_in && done_pend_q;
                end else if (push_ok) begin
                    state_d = PW_RUN;
                end
            end
            PW_RUN: begin
                if (done_in) state_d = PW_FLUSH;
            end
            PW_FLUSH: begin
                if (done_in) done_pend_d = 1'b1;
                if (drained) state_d = PW_DONE;
            end
            PW_DONE: begin
                if (done_in) done_pend_d = 1'b1;
                state_d = PW_IDLE;
            end
            default: state_d = PW_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q     <= PW_IDLE;
            done_pend_q <= 1'b0;
            stall_q     <= 1'b0;
            overflow_q  <= 1'b0;
            mem_write_q <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
        end else begin
            state_q     <= state_d;
            done_pend_q <= done_pend_d;
            stall_q     <= stall_d;
            overflow_q  <= overflow_d;
            mem_write_q <= mem_write_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
        end
    end

    assign stall_out      = stall_q;
    assign overflow       = overflow_q;
    assign mem_write      = mem_write_q;
    assign mem_address    = addr_q;
    assign mem_writedata  = wdata_q;
    assign mem_byteenable = 4'b0111;
    assign done_out       = (state_q == PW_DONE);
    assign dbg_state      = state_q;

endmodule

// File: tb/tb_fb_pixel_writer.sv
// Scenario bench for fb_pixel_writer: random pixels against a queue model of the frame-buffer writes.
module tb_fb_pixel_writer;

    localparam int A_W    = 26;
    localparam int C_W    = 24;
    localparam int DEPTH  = 8;
    localparam int MARGIN = 2;

    logic                   clock = 1'b0;
    logic                   reset = 1'b0;
    logic [A_W-1:0]         pix_addr = '0;
    logic [C_W-1:0]         pix_color = '0;
    logic                   pix_valid = 1'b0;
    logic                   done_in = 1'b0;
    logic                   stall_out;
    logic [A_W-1:0]         mem_address;
    logic [31:0]            mem_writedata;
    logic [3:0]             mem_byteenable;
    logic                   mem_write;
    logic                   mem_waitrequest = 1'b0;
    logic                   done_out;
    logic                   overflow;
    raster_pkg::pw_state_t  dbg_state;

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    logic [A_W+31:0] exp_q[$];
    logic [A_W+31:0] wr_q[$];
    int              wr_cyc[$];
    int              done_cyc[$];
    int              mw_cycles = 0;
    int              be_bad = 0;
    int              unstable = 0;
    logic            prev_hold = 1'b0;
    logic [A_W-1:0]  prev_addr = '0;
    logic [31:0]     prev_data = '0;
    logic            rst_seen = 1'b0;

    fb_pixel_writer #(
        .ADDR_W(A_W), .COLOR_W(C_W), .FIFO_DEPTH(DEPTH), .STALL_MARGIN(MARGIN)
    ) dut (
        .clock           (clock),
        .reset           (reset),
        .pix_addr        (pix_addr),
        .pix_color       (pix_color),
        .pix_valid       (pix_valid),
        .done_in         (done_in),
        .stall_out       (stall_out),
        .mem_address     (mem_address),
        .mem_writedata   (mem_writedata),
        .mem_byteenable  (mem_byteenable),
        .mem_write       (mem_write),
        .mem_waitrequest (mem_waitrequest),
        .done_out        (done_out),
        .overflow        (overflow),
        .dbg_state       (dbg_state)
    );

    // ---------------- clock / reset ----------------
    always #5 clock = ~clock;

    always @(posedge clock) begin
        cyc      <= cyc + 1;
        rst_seen <= reset;
    end

    // ---------------- bus monitor (samples on the falling edge) ----------------
    always @(negedge clock) begin
        if (mem_byteenable !== 4'b0111) be_bad++;
        if (mem_write === 1'b1) mw_cycles++;
        if (rst_seen === 1'b1 && prev_hold &&
            (mem_write !== 1'b1 || mem_address !== prev_addr || mem_writedata !== prev_data))
            unstable++;
        if (mem_write === 1'b1 && mem_waitrequest === 1'b0) begin
            wr_q.push_back({mem_address, mem_writedata});
            wr_cyc.push_back(cyc);
        end
        if (done_out === 1'b1) done_cyc.push_back(cyc);
        prev_hold = (mem_write === 1'b1) && (mem_waitrequest === 1'b1);
        prev_addr = mem_address;
        prev_data = mem_writedata;
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic clear_logs();
        wr_q.delete();
        wr_cyc.delete();
        done_cyc.delete();
        exp_q.delete();
    endtask

    // Drives one random pixel for the coming edge and returns its expected bus word.
    task automatic drive_rand_pixel(output logic [A_W+31:0] word);
        pix_addr  = A_W'($urandom);
        pix_color = C_W'($urandom);
        pix_valid = 1'b1;
        word      = {pix_addr, 8'h00, pix_color};
    endtask

    task automatic wait_writes(input int n, input int budget);
        for (int i = 0; i < budget && wr_q.size() < n; i++) tick();
    endtask

    task automatic wait_dones(input int n, input int budget);
        for (int i = 0; i < budget && done_cyc.size() < n; i++) tick();
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        reset = 1'b0;
        mem_waitrequest = 1'b0;
        repeat (3) tick();
        @(negedge clock);
        checks++; if (mem_write !== 1'b0) begin failures++; $display("FAIL reset_mem_write got=%0b exp=0", mem_write); end
        checks++; if (stall_out !== 1'b0) begin failures++; $display("FAIL reset_stall got=%0b exp=0", stall_out); end
        checks++; if (done_out !== 1'b0) begin failures++; $display("FAIL reset_done got=%0b exp=0", done_out); end
        checks++; if (overflow !== 1'b0) begin failures++; $display("FAIL reset_overflow got=%0b exp=0", overflow); end
        checks++; if (mem_address !== '0) begin failures++; $display("FAIL reset_address got=%0h exp=0", mem_address); end
        checks++; if (mem_writedata !== 32'h0) begin failures++; $display("FAIL reset_writedata got=%0h exp=0", mem_writedata); end
        checks++; if (mem_byteenable !== 4'b0111) begin failures++; $display("FAIL reset_byteenable got=%0b exp=0111", mem_byteenable); end
        tick();
        reset = 1'b1;
        repeat (2) tick();
    endtask

    task automatic test_single();
        int t0;
        int mw0;
        logic [A_W+31:0] got;
        clear_logs();
        mem_waitrequest = 1'b0;
        mw0 = mw_cycles;
        pix_addr  = 26'h000100;
        pix_color = 24'hFF8040;
        pix_valid = 1'b1;
        t0 = cyc;
        tick();
        pix_valid = 1'b0;
        repeat (6) tick();
        got = (wr_q.size() > 0) ? wr_q[0] : 'x;
        checks++; if (wr_q.size() != 1) begin failures++; $display("FAIL single_count got=%0d exp=1", wr_q.size()); end
        checks++; if (got !== {26'h000100, 32'h00FF8040}) begin failures++; $display("FAIL single_word got=%0h exp=%0h", got, {26'h000100, 32'h00FF8040}); end
        checks++; if (wr_cyc.size() == 0 || wr_cyc[0] != t0 + 2) begin failures++; $display("FAIL single_latency got=%0d exp=%0d", (wr_cyc.size() > 0) ? wr_cyc[0] : -1, t0 + 2); end
        checks++; if (mw_cycles - mw0 != 1) begin failures++; $display("FAIL single_write_width got=%0d exp=1", mw_cycles - mw0); end
        checks++; if (be_bad != 0) begin failures++; $display("FAIL byteenable_const got=%0d bad_cycles exp=0", be_bad); end
    endtask

    task automatic test_back_to_back();
        int t0;
        int bad_order;
        int bad_timing;
        int last;
        logic [A_W+31:0] w;
        clear_logs();
        mem_waitrequest = 1'b0;
        t0 = cyc;
        for (int i = 0; i < 10; i++) begin
            drive_rand_pixel(w);
            exp_q.push_back(w);
            tick();
        end
        pix_valid = 1'b0;
        done_in = 1'b1;
        tick();
        done_in = 1'b0;
        wait_dones(1, 40);
        repeat (3) tick();
        bad_order = 0;
        bad_timing = 0;
        for (int i = 0; i < 10 && i < wr_q.size(); i++) begin
            if (wr_q[i] !== exp_q[i]) bad_order++;
            if (wr_cyc[i] != t0 + 2 + i) bad_timing++;
        end
        last = (wr_cyc.size() > 0) ? wr_cyc[wr_cyc.size()-1] : 0;
        checks++; if (wr_q.size() != 10) begin failures++; $display("FAIL burst_count got=%0d exp=10", wr_q.size()); end
        checks++; if (bad_order != 0) begin failures++; $display("FAIL burst_order got=%0d wrong_words exp=0", bad_order); end
        checks++; if (bad_timing != 0) begin failures++; $display("FAIL burst_one_per_cycle got=%0d off_cycle_words exp=0", bad_timing); end
        checks++; if (done_cyc.size() != 1) begin failures++; $display("FAIL burst_done_pulses got=%0d exp=1", done_cyc.size()); end
        checks++; if (done_cyc.size() == 0 || done_cyc[0] <= last || done_cyc[0] > last + 3) begin
            failures++; $display("FAIL burst_done_timing got=%0d exp=after %0d", (done_cyc.size() > 0) ? done_cyc[0] : -1, last);
        end
    endtask

    task automatic test_waitrequest_stall();
        int sent;
        int u0;
        int bad_order;
        logic [A_W+31:0] w;
        clear_logs();
        mem_waitrequest = 1'b1;
        u0 = unstable;
        sent = 0;
        // Source honours stall_out as it sees it when it decides whether to send.
        for (int i = 0; i < 14; i++) begin
            if (stall_out !== 1'b1 && sent < 10) begin
                drive_rand_pixel(w);
                exp_q.push_back(w);
                sent++;
            end else begin
                pix_valid = 1'b0;
            end
            tick();
        end
        pix_valid = 1'b0;
        tick();
        // Bus blocked: one pixel sits in the output register, so stall fires with DEPTH-MARGIN+1 sent.
        checks++; if (sent != DEPTH - MARGIN + 1) begin failures++; $display("FAIL stall_threshold got=%0d sent exp=%0d", sent, DEPTH - MARGIN + 1); end
        checks++; if (stall_out !== 1'b1) begin failures++; $display("FAIL stall_high got=%0b exp=1", stall_out); end
        checks++; if (mem_write !== 1'b1) begin failures++; $display("FAIL wait_hold_write got=%0b exp=1", mem_write); end
        checks++; if (wr_q.size() != 0) begin failures++; $display("FAIL wait_no_transfer got=%0d exp=0", wr_q.size()); end
        mem_waitrequest = 1'b0;
        wait_writes(sent, 30);
        repeat (3) tick();
        bad_order = 0;
        for (int i = 0; i < exp_q.size() && i < wr_q.size(); i++)
            if (wr_q[i] !== exp_q[i]) bad_order++;
        checks++; if (wr_q.size() != sent) begin failures++; $display("FAIL wait_count got=%0d exp=%0d", wr_q.size(), sent); end
        checks++; if (bad_order != 0) begin failures++; $display("FAIL wait_order got=%0d wrong_words exp=0", bad_order); end
        checks++; if (unstable != u0) begin failures++; $display("FAIL wait_stable got=%0d unstable_cycles exp=0", unstable - u0); end
        checks++; if (overflow !== 1'b0) begin failures++; $display("FAIL wait_no_overflow got=%0b exp=0", overflow); end
        checks++; if (stall_out !== 1'b0) begin failures++; $display("FAIL stall_release got=%0b exp=0", stall_out); end
    endtask

    task automatic test_done_marker();
        int t0;
        int bad_order;
        logic [A_W+31:0] w;
        clear_logs();
        mem_waitrequest = 1'b0;
        tick();
        done_in = 1'b1;
        t0 = cyc;
        tick();
        done_in = 1'b0;
        repeat (6) tick();
        checks++; if (done_cyc.size() != 1) begin failures++; $display("FAIL empty_done_pulses got=%0d exp=1", done_cyc.size()); end
        checks++; if (done_cyc.size() == 0 || done_cyc[0] != t0 + 2) begin failures++; $display("FAIL empty_done_timing got=%0d exp=%0d", (done_cyc.size() > 0) ? done_cyc[0] : -1, t0 + 2); end
        checks++; if (wr_q.size() != 0) begin failures++; $display("FAIL empty_done_writes got=%0d exp=0", wr_q.size()); end

        // Last pixel shares its cycle with done_in; a second done arrives while flushing.
        clear_logs();
        mem_waitrequest = ($urandom_range(0, 1) == 1) ? 1'b1 : 1'b0;
        for (int i = 0; i < 3; i++) begin
            drive_rand_pixel(w);
            exp_q.push_back(w);
            done_in = (i == 2);
            tick();
        end
        pix_valid = 1'b0;
        done_in = 1'b1;
        tick();
        done_in = 1'b0;
        repeat ($urandom_range(0, 3)) tick();
        mem_waitrequest = 1'b0;
        wait_dones(2, 40);
        repeat (2) tick();
        bad_order = 0;
        for (int i = 0; i < 3 && i < wr_q.size(); i++)
            if (wr_q[i] !== exp_q[i]) bad_order++;
        checks++; if (wr_q.size() != 3 || bad_order != 0) begin failures++; $display("FAIL done_pixels got=%0d words %0d wrong exp=3 words 0 wrong", wr_q.size(), bad_order); end
        checks++; if (done_cyc.size() != 2) begin failures++; $display("FAIL second_done_pulses got=%0d exp=2", done_cyc.size()); end
        checks++; if (done_cyc.size() < 1 || wr_cyc.size() < 3 || done_cyc[0] <= wr_cyc[2]) begin
            failures++; $display("FAIL done_after_last_write got=%0d exp=after %0d", (done_cyc.size() > 0) ? done_cyc[0] : -1, (wr_cyc.size() > 2) ? wr_cyc[2] : -1);
        end
        checks++; if (done_cyc.size() == 2 && done_cyc[1] <= done_cyc[0] + 1) begin
            failures++; $display("FAIL second_done_separate got=%0d exp=after %0d", done_cyc[1], done_cyc[0] + 1);
        end
    endtask

    task automatic test_overflow();
        logic [A_W+31:0] sent_q[$];
        logic [A_W+31:0] w;
        int bad_order;
        clear_logs();
        mem_waitrequest = 1'b1;
        for (int i = 0; i < 12; i++) begin
            drive_rand_pixel(w);
            sent_q.push_back(w);
            tick();
        end
        pix_valid = 1'b0;
        tick();
        // With the bus blocked from an empty start, capacity is the FIFO plus the output register.
        for (int i = 0; i < DEPTH + 1; i++) exp_q.push_back(sent_q[i]);
        checks++; if (overflow !== 1'b1) begin failures++; $display("FAIL overflow_set got=%0b exp=1", overflow); end
        checks++; if (stall_out !== 1'b1) begin failures++; $display("FAIL overflow_stall got=%0b exp=1", stall_out); end
        mem_waitrequest = 1'b0;
        wait_writes(exp_q.size() + 1, 30);
        bad_order = 0;
        for (int i = 0; i < exp_q.size() && i < wr_q.size(); i++)
            if (wr_q[i] !== exp_q[i]) bad_order++;
        checks++; if (wr_q.size() != exp_q.size()) begin failures++; $display("FAIL overflow_kept got=%0d exp=%0d", wr_q.size(), exp_q.size()); end
        checks++; if (bad_order != 0) begin failures++; $display("FAIL overflow_order got=%0d wrong_words exp=0", bad_order); end
        checks++; if (overflow !== 1'b1) begin failures++; $display("FAIL overflow_sticky got=%0b exp=1", overflow); end
    endtask

    task automatic test_reset_mid_burst();
        logic [A_W+31:0] w;
        logic [A_W+31:0] got;
        clear_logs();
        mem_waitrequest = 1'b1;
        for (int i = 0; i < DEPTH; i++) begin
            drive_rand_pixel(w);
            tick();
        end
        pix_valid = 1'b0;
        tick();
        checks++; if (mem_write !== 1'b1 || stall_out !== 1'b1) begin failures++; $display("FAIL pre_reset_busy got=%0b%0b exp=11", mem_write, stall_out); end
        reset = 1'b0;
        tick();
        @(negedge clock);
        checks++; if (mem_write !== 1'b0) begin failures++; $display("FAIL midreset_mem_write got=%0b exp=0", mem_write); end
        checks++; if (stall_out !== 1'b0) begin failures++; $display("FAIL midreset_stall got=%0b exp=0", stall_out); end
        checks++; if (overflow !== 1'b0) begin failures++; $display("FAIL midreset_overflow got=%0b exp=0", overflow); end
        tick();
        reset = 1'b1;
        mem_waitrequest = 1'b0;
        repeat (2) tick();
        clear_logs();
        drive_rand_pixel(w);
        tick();
        pix_valid = 1'b0;
        repeat (12) tick();
        got = (wr_q.size() > 0) ? wr_q[0] : 'x;
        checks++; if (wr_q.size() != 1) begin failures++; $display("FAIL postreset_count got=%0d exp=1", wr_q.size()); end
        checks++; if (got !== w) begin failures++; $display("FAIL postreset_word got=%0h exp=%0h", got, w); end
        checks++; if (be_bad != 0) begin failures++; $display("FAIL byteenable_final got=%0d bad_cycles exp=0", be_bad); end
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_waitrequest_stall();
        test_done_marker();
        test_overflow();
        test_reset_mid_burst();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog got=timeout exp=completion");
        $fatal(1, "watchdog expired");
    end

endmodule
